// File: rtl/sram_slot_arbiter_if.sv
// Bundle of slot-control, write-queue and SRAM bus signals for sram_slot_arbiter.
// The master modport is the arbiter's view; slave is the surrounding system's view.
interface sram_slot_arbiter_if #(
    parameter int X_BITS          = 9,
    parameter int Y_BITS          = 8,
    parameter int DATA_BITS       = 8,
    parameter int PIXELS_PER_SLOT = 2
);
    localparam int ADDR_BITS = X_BITS + Y_BITS;

    logic                                 slot_start;
    logic [X_BITS-1:0]                    read_x;
    logic [Y_BITS-1:0]                    read_y;
    logic [PIXELS_PER_SLOT*DATA_BITS-1:0] pixels;
    logic                                 pixels_valid;
    logic                                 slot_overrun;
    logic [ADDR_BITS+DATA_BITS-1:0]       wq_data;
    logic                                 wq_empty;
    logic                                 wq_pop;
    logic [ADDR_BITS-1:0]                 sram_addr;
    logic [DATA_BITS-1:0]                 sram_data_in;
    logic [DATA_BITS-1:0]                 sram_data_out;
    logic                                 sram_data_oe;
    logic                                 sram_oe_n;
    logic                                 sram_we_n;

    modport master (
        input  slot_start, read_x, read_y, wq_data, wq_empty, sram_data_in,
        output pixels, pixels_valid, slot_overrun, wq_pop,
               sram_addr, sram_data_out, sram_data_oe, sram_oe_n, sram_we_n
    );

    modport slave (
        output slot_start, read_x, read_y, wq_data, wq_empty, sram_data_in,
        input  pixels, pixels_valid, slot_overrun, wq_pop,
               sram_addr, sram_data_out, sram_data_oe, sram_oe_n, sram_we_n
    );
endinterface

// File: rtl/sram_slot_arbiter.sv
// Framebuffer SRAM arbiter: each slot reads PIXELS_PER_SLOT pixels, then drains up to WRITES_PER_SLOT queued writes.
// Build option TRANSPARENT_SKIP_EN: queue entries whose data equals TRANSPARENT_COLOR are popped but not written.
module sram_slot_arbiter #(
    parameter int                   X_BITS            = 9,
    parameter int                   Y_BITS            = 8,
    parameter int                   DATA_BITS         = 8,
    parameter int                   PIXELS_PER_SLOT   = 2,
    parameter int                   WRITES_PER_SLOT   = 1,
    parameter logic [DATA_BITS-1:0] TRANSPARENT_COLOR = '0
) (
    input logic                 clock,
    input logic                 reset,
    sram_slot_arbiter_if.master bus
);
    localparam int ADDR_BITS = X_BITS + Y_BITS;
    localparam int K_W       = (PIXELS_PER_SLOT > 1) ? $clog2(PIXELS_PER_SLOT) : 1;
    localparam int WD_W      = $clog2(WRITES_PER_SLOT + 2);
    localparam logic [K_W-1:0]  K_LAST = K_W'(PIXELS_PER_SLOT - 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WRITES_PER_SLOT);

`ifdef TRANSPARENT_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_LATCH,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD
    } state_t;

    state_t                               r_state;
    logic [K_W-1:0]                       r_k;
    logic [WD_W-1:0]                      r_writes_done;
    logic [X_BITS-1:0]                    r_x_q;
    logic [Y_BITS-1:0]                    r_y_q;
    logic                                 r_skip;
    logic [ADDR_BITS-1:0]                 r_sram_addr;
    logic [DATA_BITS-1:0]                 r_sram_data_out;
    logic                                 r_sram_data_oe;
    logic                                 r_sram_oe_n;
    logic                                 r_sram_we_n;
    logic [PIXELS_PER_SLOT*DATA_BITS-1:0] r_pixels;
    logic                                 r_pixels_valid;
    logic                                 r_slot_overrun;
    logic                                 r_wq_pop;

    logic [ADDR_BITS-1:0] w_wq_addr;
    logic [DATA_BITS-1:0] w_wq_data;
    logic                 w_wq_skip;
    logic [X_BITS-1:0]    w_next_x;
    logic                 w_decide;
    logic                 w_take;

    assign w_wq_addr = bus.wq_data[DATA_BITS +: ADDR_BITS];
    assign w_wq_data = bus.wq_data[DATA_BITS-1:0];
    assign w_wq_skip = SKIP_EN && (w_wq_data == TRANSPARENT_COLOR);
    // x wraps modulo 2^X_BITS; y stays fixed for the whole slot
    assign w_next_x  = r_x_q + X_BITS'(r_k) + X_BITS'(1);

    // Write decisions happen only after the last read latch and at the end of each WR_HOLD
    assign w_decide  = ((r_state == RD_LATCH) && (r_k == K_LAST)) || (r_state == WR_HOLD);
    assign w_take    = (r_writes_done < WD_MAX) && !bus.wq_empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_k             <= '0;
            r_writes_done   <= '0;
            r_x_q           <= '0;
            r_y_q           <= '0;
            r_skip          <= 1'b0;
            r_sram_addr     <= '0;
            r_sram_data_out <= '0;
            r_sram_data_oe  <= 1'b0;
            r_sram_oe_n     <= 1'b1;
            r_sram_we_n     <= 1'b1;
            r_pixels        <= '0;
            r_pixels_valid  <= 1'b0;
            r_slot_overrun  <= 1'b0;
            r_wq_pop        <= 1'b0;
        end else begin
            r_pixels_valid <= 1'b0;
            r_wq_pop       <= 1'b0;
            r_slot_overrun <= bus.slot_start && (r_state != IDLE);

            if (r_state == RD_LATCH) begin
                r_pixels[r_k*DATA_BITS +: DATA_BITS] <= bus.sram_data_in;
            end

            if (w_decide) begin
                r_pixels_valid <= (r_state == RD_LATCH);
                if (w_take) begin
                    r_state         <= WR_SETUP;
                    r_wq_pop        <= 1'b1;
                    r_skip          <= w_wq_skip;
                    r_sram_addr     <= w_wq_addr;
                    r_sram_data_out <= w_wq_data;
                    r_sram_data_oe  <= !w_wq_skip;
                    r_sram_oe_n     <= 1'b1;
                    r_sram_we_n     <= 1'b1;
                end else begin
                    r_state        <= IDLE;
                    r_skip         <= 1'b0;
                    r_sram_data_oe <= 1'b0;
                    r_sram_oe_n    <= 1'b1;
                    r_sram_we_n    <= 1'b1;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.slot_start) begin
                            r_x_q         <= bus.read_x;
                            r_y_q         <= bus.read_y;
                            r_k           <= '0;
                            r_writes_done <= '0;
                            r_sram_addr   <= {bus.read_y, bus.read_x};
                            r_sram_oe_n   <= 1'b0;
                            r_state       <= RD_ADDR;
                        end
                    end
                    RD_ADDR: begin
                        r_state <= RD_LATCH;
                    end
                    RD_LATCH: begin
                        r_k         <= r_k + K_W'(1);
                        r_sram_addr <= {r_y_q, w_next_x};
                        r_state     <= RD_ADDR;
                    end
                    WR_SETUP: begin
                        // A skipped entry still passes through WR_HOLD so the next decision sees the post-pop FIFO head
                        if (r_skip) begin
                            r_writes_done <= r_writes_done + WD_W'(1);
                            r_state       <= WR_HOLD;
                        end else begin
                            r_sram_we_n <= 1'b0;
                            r_state     <= WR_STROBE;
                        end
                    end
                    WR_STROBE: begin
                        r_sram_we_n   <= 1'b1;
                        r_writes_done <= r_writes_done + WD_W'(1);
                        r_state       <= WR_HOLD;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sram_addr     = r_sram_addr;
    assign bus.sram_data_out = r_sram_data_out;
    assign bus.sram_data_oe  = r_sram_data_oe;
    assign bus.sram_oe_n     = r_sram_oe_n;
    assign bus.sram_we_n     = r_sram_we_n;
    assign bus.pixels        = r_pixels;
    assign bus.pixels_valid  = r_pixels_valid;
    assign bus.slot_overrun  = r_slot_overrun;
    assign bus.wq_pop        = r_wq_pop;
endmodule

// File: tb/tb_sram_slot_arbiter.sv
// Directed bench for sram_slot_arbiter: a P=2/W=2 instance with SRAM and FIFO models,
// plus a P=4/W=0 instance for x wrap and the never-pop case.
module tb_sram_slot_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_slot_arbiter_if #(.X_BITS(9), .Y_BITS(8), .DATA_BITS(8), .PIXELS_PER_SLOT(2)) ifa ();
    sram_slot_arbiter_if #(.X_BITS(9), .Y_BITS(8), .DATA_BITS(8), .PIXELS_PER_SLOT(4)) ifb ();

    sram_slot_arbiter #(.X_BITS(9), .Y_BITS(8), .DATA_BITS(8), .PIXELS_PER_SLOT(2),
                        .WRITES_PER_SLOT(2), .TRANSPARENT_COLOR(8'h00))
        dut_a (.clock(clk), .reset(rst_n), .bus(ifa));
    sram_slot_arbiter #(.X_BITS(9), .Y_BITS(8), .DATA_BITS(8), .PIXELS_PER_SLOT(4),
                        .WRITES_PER_SLOT(0), .TRANSPARENT_COLOR(8'h00))
        dut_b (.clock(clk), .reset(rst_n), .bus(ifb));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // SRAM models with a backdoor preload port
    bit [7:0]    mem_a [131072];
    bit [7:0]    mem_b [131072];
    logic        pl_en = 1'b0;
    logic        pl_sel = 1'b0;
    logic [16:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    always @(posedge clk) begin
        if (pl_en && !pl_sel) mem_a[pl_addr] <= pl_data;
        else if (!ifa.sram_we_n) mem_a[ifa.sram_addr] <= ifa.sram_data_out;
    end
    always @(posedge clk) begin
        if (pl_en && pl_sel) mem_b[pl_addr] <= pl_data;
    end
    assign ifa.sram_data_in = mem_a[ifa.sram_addr];
    assign ifb.sram_data_in = mem_b[ifb.sram_addr];

    // Show-ahead FIFO for instance A; instance B always sees a non-empty queue
    bit [24:0] fq [8];
    int        fq_wr = 0;
    int        fq_rd = 0;
    int        underflow = 0;
    int        pops_b = 0;
    int        clash = 0;
    assign ifa.wq_empty = (fq_rd == fq_wr);
    assign ifa.wq_data  = fq[fq_rd[2:0]];
    assign ifb.wq_empty = 1'b0;
    assign ifb.wq_data  = {17'h00123, 8'h5A};

    always @(posedge clk) begin
        if (ifa.wq_pop) begin
            if (fq_rd != fq_wr) fq_rd <= fq_rd + 1;
            else underflow <= underflow + 1;
        end
        if (ifb.wq_pop) pops_b <= pops_b + 1;
    end
    always @(negedge clk) begin
        if ((!ifa.sram_oe_n && ifa.sram_data_oe) || (!ifb.sram_oe_n && ifb.sram_data_oe))
            clash <= clash + 1;
    end

    task automatic push(input logic [16:0] a, input logic [7:0] d);
        fq[fq_wr[2:0]] = {a, d};
        fq_wr = fq_wr + 1;
    endtask

    task automatic pl(input logic sel, input logic [16:0] a, input logic [7:0] d);
        pl_sel  = sel;
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Per-cycle traces: bit n is the value seen after clock edge n (edge 0 samples slot_start)
    bit [31:0]   m_pv, m_pop, m_wel, m_oel, m_doe, m_ovr;
    logic [16:0] tr_addr [32];

    task automatic run_a(input logic [8:0] x, input logic [7:0] y, input int ovr_at, input int ncyc);
        m_pv = '0; m_pop = '0; m_wel = '0; m_oel = '0; m_doe = '0; m_ovr = '0;
        ifa.slot_start = 1'b1;
        ifa.read_x     = x;
        ifa.read_y     = y;
        for (int n = 0; n < ncyc; n++) begin
            @(posedge clk);
            @(negedge clk);
            ifa.slot_start = ((n + 1) == ovr_at);
            m_pv[n]    = ifa.pixels_valid;
            m_pop[n]   = ifa.wq_pop;
            m_wel[n]   = !ifa.sram_we_n;
            m_oel[n]   = !ifa.sram_oe_n;
            m_doe[n]   = ifa.sram_data_oe;
            m_ovr[n]   = ifa.slot_overrun;
            tr_addr[n] = ifa.sram_addr;
        end
        ifa.slot_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [15:0] pix;
    } rd_vec_t;

    rd_vec_t     rv [4];
    logic [8:0]  x1;
    logic [16:0] a0, a2;
    bit [31:0]   b_pv, b_oel;
    logic [16:0] b_addr [8];

    initial begin
        rv[0] = '{x: 9'd10,  y: 8'd5,   pix: 16'hB2A1};
        rv[1] = '{x: 9'd511, y: 8'd3,   pix: 16'h1277};
        rv[2] = '{x: 9'd0,   y: 8'd255, pix: 16'h5AEE};
        rv[3] = '{x: 9'd200, y: 8'd0,   pix: 16'h8001};

        ifa.slot_start = 1'b0; ifa.read_x = '0; ifa.read_y = '0;
        ifb.slot_start = 1'b0; ifb.read_x = '0; ifb.read_y = '0;
        @(negedge clk);

        check("reset_we_n",         ifa.sram_we_n,     1);
        check("reset_oe_n",         ifa.sram_oe_n,     1);
        check("reset_data_oe",      ifa.sram_data_oe,  0);
        check("reset_addr",         ifa.sram_addr,     0);
        check("reset_data_out",     ifa.sram_data_out, 0);
        check("reset_pixels",       ifa.pixels,        0);
        check("reset_pixels_valid", ifa.pixels_valid,  0);
        check("reset_pop_overrun",  {ifa.wq_pop, ifa.slot_overrun}, 0);

        pl(1'b0, 17'h00A0A, 8'hA1); pl(1'b0, 17'h00A0B, 8'hB2);
        pl(1'b0, 17'h007FF, 8'h77); pl(1'b0, 17'h00600, 8'h12);
        pl(1'b0, 17'h1FE00, 8'hEE); pl(1'b0, 17'h1FE01, 8'h5A);
        pl(1'b0, 17'h000C8, 8'h01); pl(1'b0, 17'h000C9, 8'h80);
        pl(1'b0, 17'h01234, 8'h11); pl(1'b0, 17'h00555, 8'hAB);
        pl(1'b1, 17'h00FFE, 8'h10); pl(1'b1, 17'h00FFF, 8'h20);
        pl(1'b1, 17'h00E00, 8'h30); pl(1'b1, 17'h00E01, 8'h40);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Read slots with an empty FIFO
        for (int i = 0; i < 4; i++) begin
            run_a(rv[i].x, rv[i].y, 0, 10);
            x1 = rv[i].x + 9'd1;
            a0 = {rv[i].y, rv[i].x};
            a2 = {rv[i].y, x1};
            check($sformatf("rd%0d_pixels", i),   ifa.pixels, rv[i].pix);
            check($sformatf("rd%0d_valid_at", i), m_pv,  32'h10);
            check($sformatf("rd%0d_oe_window", i), m_oel, 32'h0F);
            check($sformatf("rd%0d_addr0", i),    tr_addr[0], a0);
            check($sformatf("rd%0d_addr2", i),    tr_addr[2], a2);
            check($sformatf("rd%0d_no_pop", i),   {m_pop, m_wel}, 0);
        end

        // Two writes per slot: third entry must wait for the next slot
        push(17'h00A10, 8'h3C); push(17'h00A11, 8'h4D); push(17'h00B00, 8'h5E);
        run_a(9'd10, 8'd5, 0, 12);
        check("wr_pop_at",      m_pop, 32'h90);
        check("wr_we_low_at",   m_wel, 32'h120);
        check("wr_data_oe_at",  m_doe, 32'h3F0);
        check("wr_oe_window",   m_oel, 32'h0F);
        check("wr_valid_at",    m_pv,  32'h10);
        check("wr_mem_a10",     mem_a[17'h00A10], 8'h3C);
        check("wr_mem_a11",     mem_a[17'h00A11], 8'h4D);
        check("wr_left_in_q",   fq_wr - fq_rd, 1);
        check("wr_pixels",      ifa.pixels, 16'hB2A1);

        run_a(9'd10, 8'd5, 0, 10);
        check("wr2_pop_at",     m_pop, 32'h10);
        check("wr2_we_low_at",  m_wel, 32'h20);
        check("wr2_data_oe_at", m_doe, 32'h70);
        check("wr2_mem_b00",    mem_a[17'h00B00], 8'h5E);
        check("wr2_q_empty",    fq_wr - fq_rd, 0);

        // slot_start while busy, and on the edge the slot returns to IDLE
        run_a(9'd10, 8'd5, 2, 10);
        check("ovr2_pulse",  m_ovr, 32'h04);
        check("ovr2_valid",  m_pv,  32'h10);
        check("ovr2_oe",     m_oel, 32'h0F);
        check("ovr2_pixels", ifa.pixels, 16'hB2A1);
        run_a(9'd10, 8'd5, 4, 10);
        check("ovr4_pulse",  m_ovr, 32'h10);
        check("ovr4_valid",  m_pv,  32'h10);
        check("ovr4_oe",     m_oel, 32'h0F);

        // Reset asserted during WR_STROBE
        push(17'h01234, 8'h99);
        ifa.slot_start = 1'b1; ifa.read_x = 9'd10; ifa.read_y = 8'd5;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            @(negedge clk);
            ifa.slot_start = 1'b0;
        end
        check("rstw_in_strobe", ifa.sram_we_n, 0);
        #1 rst_n = 1'b0;
        #1;
        check("rstw_we_n",    ifa.sram_we_n,    1);
        check("rstw_data_oe", ifa.sram_data_oe, 0);
        check("rstw_oe_n",    ifa.sram_oe_n,    1);
        check("rstw_pixels",  ifa.pixels,       0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstw_entry_lost", fq_wr - fq_rd, 0);
        check("rstw_mem_kept",   mem_a[17'h01234], 8'h11);
        run_a(9'd10, 8'd5, 0, 10);
        check("rstw_idle_ovr",   m_ovr, 0);
        check("rstw_idle_valid", m_pv,  32'h10);
        check("rstw_pixels2",    ifa.pixels, 16'hB2A1);

        // x wrap on the P=4 instance; W=0 never pops even with a non-empty queue
        b_pv = '0; b_oel = '0;
        ifb.slot_start = 1'b1; ifb.read_x = 9'd510; ifb.read_y = 8'd7;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            @(negedge clk);
            ifb.slot_start = 1'b0;
            b_pv[n]  = ifb.pixels_valid;
            b_oel[n] = !ifb.sram_oe_n;
            if (n < 8) b_addr[n] = ifb.sram_addr;
        end
        check("wrap_pixels",   ifb.pixels, 32'h40302010);
        check("wrap_valid_at", b_pv,  32'h100);
        check("wrap_oe",       b_oel, 32'hFF);
        check("wrap_addr0",    b_addr[0], 17'h00FFE);
        check("wrap_addr2",    b_addr[2], 17'h00FFF);
        check("wrap_addr4",    b_addr[4], 17'h00E00);
        check("wrap_addr6",    b_addr[6], 17'h00E01);
        check("wrap_no_pop",   pops_b, 0);

        // Entry carrying the transparent colour
        push(17'h00555, 8'h00); push(17'h00556, 8'h66);
        run_a(9'd10, 8'd5, 0, 12);
`ifdef TRANSPARENT_SKIP_EN
        check("skip_pop_at",     m_pop, 32'h50);
        check("skip_we_low_at",  m_wel, 32'h80);
        check("skip_data_oe_at", m_doe, 32'h1C0);
        check("skip_mem_555",    mem_a[17'h00555], 8'hAB);
`else
        check("skip_pop_at",     m_pop, 32'h90);
        check("skip_we_low_at",  m_wel, 32'h120);
        check("skip_data_oe_at", m_doe, 32'h3F0);
        check("skip_mem_555",    mem_a[17'h00555], 8'h00);
`endif
        check("skip_mem_556",    mem_a[17'h00556], 8'h66);

        check("bus_clash_count", clash, 0);
        check("pop_underflow",   underflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
